// File: rtl/mouse_packet_tx.sv
// Device-side mouse link transmitter: serialises a 3-byte packet as three
// 11-bit frames (start, D0..D7, odd parity, stop) on dev_clk/dev_data.
module mouse_packet_tx #(
    parameter int unsigned HALF_PERIOD = 1667,
    parameter int unsigned DATA_HOLD   = 27,
    parameter int unsigned GAP_CYCLES  = 3334
) (
    input  logic        ck,
    input  logic        reset,
    input  logic        pkt_valid,
    input  logic [23:0] pkt_data,
    output logic        pkt_ready,
    input  logic        inhibit,
    output logic        dev_clk,
    output logic        dev_data,
    output logic        busy,
    output logic        done,
    output logic        aborted
);

    localparam int unsigned MAXP = (GAP_CYCLES > HALF_PERIOD) ? GAP_CYCLES : HALF_PERIOD;
    localparam int unsigned CW   = $clog2(MAXP);
    localparam int unsigned FW   = 10;

    typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [3:0]      bit_idx, bit_idx_n;
    logic [1:0]      byte_idx, byte_idx_n;
    logic [FW-1:0]   sr, sr_n;
    logic [23:0]     pkt_q, pkt_q_n;
    logic            dev_clk_n, dev_data_n, pkt_ready_n, busy_n, done_n, aborted_n;

    // Bits following the start bit, in transmit order from bit 0: D0..D7, parity, stop.
    function automatic logic [FW-1:0] frame(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        byte_idx_n  = byte_idx;
        sr_n        = sr;
        pkt_q_n     = pkt_q;
        dev_clk_n   = dev_clk;
        dev_data_n  = dev_data;
        busy_n      = busy;
        pkt_ready_n = 1'b0;
        done_n      = 1'b0;
        aborted_n   = 1'b0;

        case (state)
            IDLE: begin
                dev_clk_n   = 1'b1;
                dev_data_n  = 1'b1;
                busy_n      = 1'b0;
                pkt_ready_n = ~inhibit;
                if (pkt_valid && pkt_ready && !inhibit) begin
                    pkt_q_n     = pkt_data;
                    byte_idx_n  = 2'd0;
                    bit_idx_n   = 4'd0;
                    sr_n        = frame(pkt_data[23:16]);
                    dev_data_n  = 1'b0;
                    busy_n      = 1'b1;
                    pkt_ready_n = 1'b0;
                    cnt_n       = CW'(HALF_PERIOD - 1);
                    state_n     = HIGH;
                end
            end
            HIGH: begin
                if (cnt == '0) begin
                    dev_clk_n = 1'b0;
                    cnt_n     = CW'(HALF_PERIOD - 1);
                    state_n   = LOW;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            LOW: begin
                // Data advances DATA_HOLD cycles after the falling edge; 1s fill behind the stop bit.
                if (cnt == CW'(HALF_PERIOD - DATA_HOLD)) begin
                    dev_data_n = sr[0];
                    sr_n       = {1'b1, sr[FW-1:1]};
                end
                if (cnt == '0) begin
                    cnt_n = CW'(HALF_PERIOD - 1);
                    if (bit_idx != 4'd10) begin
                        bit_idx_n = bit_idx + 4'd1;
                        dev_clk_n = 1'b1;
                        state_n   = HIGH;
                    end else if (byte_idx != 2'd2) begin
                        dev_clk_n  = 1'b1;
                        dev_data_n = 1'b1;
                        cnt_n      = CW'(GAP_CYCLES - 1);
                        state_n    = GAP;
                    end else begin
                        dev_clk_n   = 1'b1;
                        dev_data_n  = 1'b1;
                        done_n      = 1'b1;
                        busy_n      = 1'b0;
                        pkt_ready_n = ~inhibit;
                        state_n     = IDLE;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            GAP: begin
                dev_clk_n  = 1'b1;
                dev_data_n = 1'b1;
                if (cnt == '0) begin
                    byte_idx_n = byte_idx + 2'd1;
                    bit_idx_n  = 4'd0;
                    sr_n       = frame(pkt_q[15:8]);
                    pkt_q_n    = {pkt_q[15:0], 8'h00};
                    dev_data_n = 1'b0;
                    cnt_n      = CW'(HALF_PERIOD - 1);
                    state_n    = HIGH;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Host inhibit discards the packet in progress
        if (state != IDLE && inhibit) begin
            state_n     = IDLE;
            cnt_n       = '0;
            dev_clk_n   = 1'b1;
            dev_data_n  = 1'b1;
            busy_n      = 1'b0;
            pkt_ready_n = 1'b0;
            done_n      = 1'b0;
            aborted_n   = 1'b1;
        end
    end

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            sr        <= '0;
            pkt_q     <= '0;
            dev_clk   <= 1'b1;
            dev_data  <= 1'b1;
            pkt_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            byte_idx  <= byte_idx_n;
            sr        <= sr_n;
            pkt_q     <= pkt_q_n;
            dev_clk   <= dev_clk_n;
            dev_data  <= dev_data_n;
            pkt_ready <= pkt_ready_n;
            busy      <= busy_n;
            done      <= done_n;
            aborted   <= aborted_n;
        end
    end

endmodule

// File: tb/tb_mouse_packet_tx.sv
// Scoreboard bench for mouse_packet_tx: expected line bits are queued by the
// stimulus and compared by a monitor at every dev_clk falling edge.
module tb_mouse_packet_tx;

    localparam int unsigned HP = 4;
    localparam int unsigned DH = 1;
    localparam int unsigned GC = 6;
    localparam int PKT_LEN = 3 * 22 * HP + 2 * GC + 1;

    // Frames as sent, bit i = i-th bit on the line (start first)
    localparam logic [10:0] F_08 = 11'b10000010000;
    localparam logic [10:0] F_01 = 11'b10000000010;
    localparam logic [10:0] F_FF = 11'b11111111110;
    localparam logic [10:0] F_2D = 11'b11001011010;
    localparam logic [10:0] F_5A = 11'b11010110100;
    localparam logic [10:0] F_B7 = 11'b11101101110;

    logic        ck = 1'b0;
    logic        reset = 1'b0;
    logic        pkt_valid = 1'b0;
    logic [23:0] pkt_data = '0;
    logic        pkt_ready;
    logic        inhibit = 1'b0;
    logic        dev_clk, dev_data, busy, done, aborted;

    int vectors = 0;
    int miscompares = 0;
    int fall_cnt = 0;
    logic exp_q[$];

    mouse_packet_tx #(.HALF_PERIOD(HP), .DATA_HOLD(DH), .GAP_CYCLES(GC)) dut (
        .ck(ck), .reset(reset), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
        .pkt_ready(pkt_ready), .inhibit(inhibit), .dev_clk(dev_clk),
        .dev_data(dev_data), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 ck = ~ck;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [10:0] f);
        for (int i = 0; i < 11; i++) exp_q.push_back(f[i]);
    endtask

    // Monitor: the reader samples dev_data on each falling edge of dev_clk
    logic prev_clk = 1'b1;
    always @(negedge ck) begin
        if (prev_clk && !dev_clk) begin
            fall_cnt++;
            if (exp_q.size() == 0) chk("unexpected_fall", 32'd1, 32'd0);
            else chk("frame_bit", 32'(dev_data), 32'(exp_q.pop_front()));
        end
        if (done || aborted) chk("done_aborted_excl", 32'(done & aborted), 32'd0);
        prev_clk = dev_clk;
    end

    task automatic step;
        @(negedge ck);
        #1;
    endtask

    task automatic wait_ready;
        for (int w = 0; w < 20 && !pkt_ready; w++) step;
        if (!pkt_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int n0, output int n, output int first);
        int base;
        base  = fall_cnt;
        first = -1;
        n     = n0;
        while (!done && n < 2000) begin
            step;
            n++;
            if (first < 0 && fall_cnt != base) first = n;
        end
    endtask

    task automatic send_and_check(input logic [23:0] d);
        int n, first;
        pkt_data  = d;
        pkt_valid = 1'b1;
        wait_ready;
        step;
        pkt_valid = 1'b0;
        pkt_data  = 24'hA5A5A5;
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_done(1, n, first);
        chk("first_fall_latency", 32'(first), 32'(HP + 1));
        chk("pkt_length", 32'(n), 32'(PKT_LEN));
        chk("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
        step;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int n, first, base, w, done_seen;

        // 1. reset state
        for (int i = 0; i < 3; i++) begin
            pkt_valid = ~pkt_valid;
            step;
            chk("rst_dev_clk", 32'(dev_clk), 32'd1);
            chk("rst_dev_data", 32'(dev_data), 32'd1);
            chk("rst_pkt_ready", 32'(pkt_ready), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        pkt_valid = 1'b0;
        reset = 1'b1;
        #1 chk("ready_before_edge", 32'(pkt_ready), 32'd0);
        step;
        chk("ready_after_release", 32'(pkt_ready), 32'd1);

        // 2. frame content and timing
        base = fall_cnt;
        push_frame(F_08); push_frame(F_01); push_frame(F_FF);
        send_and_check(24'h0801FF);
        chk("falls_per_packet", 32'(fall_cnt - base), 32'd33);

        // 3. second pattern
        push_frame(F_2D); push_frame(F_5A); push_frame(F_B7);
        send_and_check(24'h2D5AB7);

        // 4. back-to-back with valid held high
        push_frame(F_08); push_frame(F_01); push_frame(F_FF);
        push_frame(F_FF); push_frame(F_01); push_frame(F_08);
        pkt_data  = 24'h0801FF;
        pkt_valid = 1'b1;
        wait_ready;
        step;
        pkt_data = 24'hFF0108;
        wait_done(1, n, first);
        chk("b2b_len1", 32'(n), 32'(PKT_LEN));
        chk("b2b_ready_at_done", 32'(pkt_ready), 32'd1);
        chk("b2b_clk_high_between", 32'(dev_clk), 32'd1);
        step;
        pkt_valid = 1'b0;
        chk("b2b_second_accepted", 32'(busy), 32'd1);
        chk("b2b_start_bit", 32'(dev_data), 32'd0);
        chk("b2b_clk_high_start", 32'(dev_clk), 32'd1);
        wait_done(1, n, first);
        chk("b2b_len2", 32'(n), 32'(PKT_LEN));
        chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        step;

        // 5. inhibit at the 5th falling edge of the first byte
        exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b1); exp_q.push_back(1'b1);
        pkt_data  = 24'h2D5AB7;
        pkt_valid = 1'b1;
        wait_ready;
        step;
        pkt_valid = 1'b0;
        base = fall_cnt;
        for (w = 0; w < 500 && fall_cnt != base + 5; w++) step;
        chk("abort_reached_5th_fall", 32'(fall_cnt - base), 32'd5);
        inhibit = 1'b1;
        step;
        chk("abort_dev_clk", 32'(dev_clk), 32'd1);
        chk("abort_dev_data", 32'(dev_data), 32'd1);
        chk("abort_pulse", 32'(aborted), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 60; i++) begin
            step;
            if (done || pkt_ready || aborted) done_seen++;
        end
        chk("abort_quiet_while_inhibit", 32'(done_seen), 32'd0);
        chk("abort_no_more_falls", 32'(fall_cnt - base), 32'd5);
        inhibit = 1'b0;
        step;
        chk("ready_after_inhibit_drop", 32'(pkt_ready), 32'd1);

        // 6. async reset during LOW, then a clean packet
        push_frame(F_08); push_frame(F_01); push_frame(F_FF);
        pkt_data  = 24'h0801FF;
        pkt_valid = 1'b1;
        wait_ready;
        step;
        pkt_valid = 1'b0;
        for (w = 0; w < 100 && dev_clk; w++) step;
        chk("reached_low", 32'(dev_clk), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_dev_clk", 32'(dev_clk), 32'd1);
        chk("async_rst_dev_data", 32'(dev_data), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        step;
        step;
        reset = 1'b1;
        step;
        push_frame(F_08); push_frame(F_01); push_frame(F_FF);
        send_and_check(24'h0801FF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule
